// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. Owns the fetch PC (count), issues word-addressed
// requests to instruction memory under a credit limit, collects in-order
// responses of variable latency into a small instruction queue, and hands the
// queue head (instruction plus its PC) to decode over a valid/ready handshake.
// A redirect (taken branch / jump) reloads the PC, flushes the queue and marks
// every request still in flight as stale so its response is thrown away.
//
// Ports
//   clk1          sole clock, rising edge
//   reset         asynchronous, active-high reset
//   imem_req      request valid to instruction memory (combinational)
//   imem_addr     request word address (always equals count)
//   imem_gnt      memory accepts the request this cycle
//   imem_rvalid   response valid (in request order, >= 1 cycle after grant)
//   imem_rdata    response instruction word
//   instr_valid   queue head valid to decode
//   instr         queue head instruction
//   instr_pc      PC of the queue head
//   instr_ready   decode consumes the head this cycle
//   redirect      taken branch or jump this cycle
//   redirect_pc   new fetch PC
//   count         current fetch PC
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int                 ADDR_W   = 8,
    parameter int                 DATA_W   = 32,
    parameter int                 DEPTH    = 2,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk1,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] count
);

    // Pointer width (DEPTH is a power of two, so pointers wrap naturally)
    // and counter width (must be able to hold the value DEPTH itself).
    localparam int            PW      = $clog2(DEPTH);
    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   CREDITS = (CW+1)'(DEPTH);

    // ---------------------------------------------------------------- state
    logic [ADDR_W-1:0] count_q, count_d;
    logic [CW-1:0]     outstanding_q, outstanding_d;
    logic [CW-1:0]     drop_q, drop_d;
    logic [CW-1:0]     occ_q, occ_d;
    logic [PW-1:0]     tag_wr_q, tag_wr_d;
    logic [PW-1:0]     tag_rd_q, tag_rd_d;
    logic [PW-1:0]     q_wr_q, q_wr_d;
    logic [PW-1:0]     q_rd_q, q_rd_d;
    logic [DATA_W-1:0] head_data_q, head_data_d;
    logic [ADDR_W-1:0] head_pc_q, head_pc_d;

    // PC tags of in-flight requests, and the instruction queue body.
    logic [ADDR_W-1:0] tag_mem    [DEPTH];
    logic [DATA_W-1:0] q_data_mem [DEPTH];
    logic [ADDR_W-1:0] q_pc_mem   [DEPTH];

    // ------------------------------------------------------------ handshakes
    logic [CW:0]       credit_sum;
    logic              gnt;
    logic              rsp;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] tag_head;

    // Queued plus in-flight may never exceed DEPTH, so a push can never find
    // the queue full.
    assign credit_sum = {1'b0, occ_q} + {1'b0, outstanding_q};
    assign imem_req   = !reset && !redirect && (credit_sum < CREDITS);
    assign imem_addr  = count_q;
    assign count      = count_q;

    assign gnt      = imem_req && imem_gnt;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp      = imem_rvalid && (outstanding_q != '0);
    assign push     = rsp && (drop_q == '0) && !redirect;
    assign pop      = instr_valid && instr_ready && !redirect;
    assign tag_head = tag_mem[tag_rd_q];

    assign instr_valid = (occ_q != '0);
    assign instr       = head_data_q;
    assign instr_pc    = head_pc_q;

    // ------------------------------------------------------------ next state
    always_comb begin
        count_d       = count_q;
        outstanding_d = outstanding_q + CW'(gnt) - CW'(rsp);
        drop_d        = drop_q;
        tag_wr_d      = tag_wr_q + PW'(gnt);
        tag_rd_d      = tag_rd_q + PW'(rsp);
        q_wr_d        = q_wr_q;
        q_rd_d        = q_rd_q;
        occ_d         = occ_q;
        head_data_d   = head_data_q;
        head_pc_d     = head_pc_q;

        if (redirect) begin
            count_d = redirect_pc;
            // Everything still in flight after this edge belongs to the old
            // path; the tag FIFO keeps popping for those so it stays aligned.
            drop_d  = outstanding_d;
            q_rd_d  = q_wr_q;
            occ_d   = '0;
        end else begin
            if (gnt) begin
                count_d = count_q + ADDR_W'(1);
            end
            if (rsp && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
            q_wr_d = q_wr_q + PW'(push);
            q_rd_d = q_rd_q + PW'(pop);
            occ_d  = occ_q + CW'(push) - CW'(pop);

            // The head registers mirror the entry at the read pointer. If the
            // queue is empty after the pop, the only entry left is the one
            // arriving now, which is not yet in the array. When the queue
            // drains the head simply holds its last value.
            if (occ_d != '0) begin
                if (occ_q == CW'(pop)) begin
                    head_data_d = imem_rdata;
                    head_pc_d   = tag_head;
                end else begin
                    head_data_d = q_data_mem[q_rd_d];
                    head_pc_d   = q_pc_mem[q_rd_d];
                end
            end
        end
    end

    // ------------------------------------------------------------- registers
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            count_q       <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            occ_q         <= '0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
            q_wr_q        <= '0;
            q_rd_q        <= '0;
            head_data_q   <= '0;
            head_pc_q     <= '0;
        end else begin
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            occ_q         <= occ_d;
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
            q_wr_q        <= q_wr_d;
            q_rd_q        <= q_rd_d;
            head_data_q   <= head_data_d;
            head_pc_q     <= head_pc_d;
        end
    end

    // Storage arrays need no reset: entries are only read once written.
    always_ff @(posedge clk1) begin
        if (gnt) begin
            tag_mem[tag_wr_q] <= count_q;
        end
        if (push) begin
            q_data_mem[q_wr_q] <= imem_rdata;
            q_pc_mem[q_wr_q]   <= tag_head;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Bench for fetch_unit. An in-order instruction memory model with a settable
// latency answers grants; each phase queues the PC / instruction pairs decode
// must see, and a monitor pops and compares them whenever decode consumes an
// instruction. Directed checks cover reset state, stalls, redirects and wrap.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic          clk1        = 1'b0;
    logic          reset       = 1'b1;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid = 1'b0;
    logic [DW-1:0] imem_rdata  = '0;
    logic          instr_valid;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_ready = 1'b0;
    logic          redirect    = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic [AW-1:0] count;

    logic          gnt_en    = 1'b1;
    bit            mem_flush = 1'b0;
    int unsigned   lat       = 1;
    int unsigned   mcyc      = 0;
    int            grant_cnt = 0;

    int tests = 0;
    int fails = 0;

    assign imem_gnt = gnt_en;

    always #5 clk1 = ~clk1;

    fetch_unit #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .DEPTH    (DEPTH),
        .RESET_PC (8'h00)
    ) dut (
        .clk1        (clk1),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .count       (count)
    );

    // Memory image: each word encodes its own address.
    function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
        return {8'hC0, a, ~a, 8'h5A};
    endfunction

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endfunction

    // ---------------------------------------------------------- scoreboard
    typedef struct {
        logic [AW-1:0] pc;
        logic [DW-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    always @(negedge clk1) begin : monitor
        exp_t e;
        if (!reset && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_instr: got pc %02h data %08h, required none",
                         instr_pc, instr);
            end else begin
                e = exp_q.pop_front();
                $display("[TB] decode pc=%02h data=%08h (expected pc=%02h data=%08h)",
                         instr_pc, instr, e.pc, e.data);
                check("instr_pc", 64'(instr_pc), 64'(e.pc));
                check("instr", 64'(instr), 64'(e.data));
            end
        end
    end

    // ---------------------------------------------------------- memory model
    typedef struct {
        logic [AW-1:0] addr;
        int unsigned   due;
    } pend_t;
    pend_t pend_q[$];

    always begin : mem_model
        pend_t p;
        @(negedge clk1);
        if (mem_flush) begin
            pend_q.delete();
        end else if (imem_req && imem_gnt) begin
            p.addr = imem_addr;
            p.due  = mcyc + lat;
            pend_q.push_back(p);
            grant_cnt++;
        end
        @(posedge clk1);
        #1;
        mcyc++;
        if (pend_q.size() != 0 && pend_q[0].due <= mcyc) begin
            p           = pend_q.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = word(p.addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
    end

    // ---------------------------------------------------------- helpers
    task automatic push_exp(input logic [AW-1:0] start, input int n);
        exp_t e;
        logic [AW-1:0] pc;
        pc = start;
        for (int i = 0; i < n; i++) begin
            e.pc   = pc;
            e.data = word(pc);
            exp_q.push_back(e);
            pc = pc + 8'd1;
        end
    endtask

    task automatic do_reset(input bit flush);
        @(posedge clk1);
        #2;
        reset       = 1'b1;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        gnt_en      = 1'b1;
        mem_flush   = flush;
        @(negedge clk1);
        check("rst_instr_valid", 64'(instr_valid), 64'd0);
        check("rst_instr", 64'(instr), 64'd0);
        check("rst_instr_pc", 64'(instr_pc), 64'd0);
        check("rst_imem_req", 64'(imem_req), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        @(posedge clk1);
        #2;
        mem_flush = 1'b0;
        reset     = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk1);
            #2;
            n++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_drain: %0d instructions still pending, required 0",
                     name, exp_q.size());
            exp_q.delete();
        end
        instr_ready = 1'b0;
    endtask

    task automatic wait_count(input string name, input logic [AW-1:0] target);
        int n;
        n = 0;
        while (count !== target && n < 40) begin
            @(posedge clk1);
            #2;
            n++;
        end
        check(name, 64'(count), 64'(target));
    endtask

    // ---------------------------------------------------------- stimulus
    initial begin
        int g0;
        int n;

        // 1: free-running, latency 1, decode always ready.
        do_reset(1'b1);
        lat = 1;
        push_exp(8'h00, 6);
        instr_ready = 1'b1;
        g0 = grant_cnt;
        @(negedge clk1);
        check("t1_first_req", 64'(imem_req), 64'd1);
        check("t1_first_addr", 64'(imem_addr), 64'd0);
        n = 0;
        while ((grant_cnt - g0) < 3 && n < 40) begin
            @(posedge clk1);
            #2;
            n++;
        end
        check("t1_count_after_3_grants", 64'(count), 64'd3);
        wait_drain("t1", 60);

        // 2: decode stalled for 6 cycles, then released.
        do_reset(1'b1);
        lat = 1;
        repeat (6) @(negedge clk1);
        check("t2_req_blocked", 64'(imem_req), 64'd0);
        check("t2_valid", 64'(instr_valid), 64'd1);
        check("t2_pc", 64'(instr_pc), 64'd0);
        check("t2_instr", 64'(instr), 64'(word(8'h00)));
        @(negedge clk1);
        check("t2_instr_stable", 64'(instr), 64'(word(8'h00)));
        check("t2_pc_stable", 64'(instr_pc), 64'd0);
        push_exp(8'h00, 4);
        @(posedge clk1);
        #2;
        instr_ready = 1'b1;
        wait_drain("t2", 60);

        // 3: latency 3, redirect to 0x40 with two requests in flight.
        do_reset(1'b1);
        lat = 3;
        push_exp(8'h40, 3);
        instr_ready = 1'b1;
        wait_count("t3_two_grants", 8'h02);
        redirect    = 1'b1;
        redirect_pc = 8'h40;
        @(negedge clk1);
        check("t3_req_during_redirect", 64'(imem_req), 64'd0);
        @(posedge clk1);
        #2;
        redirect = 1'b0;
        @(negedge clk1);
        check("t3_valid_after_redirect", 64'(instr_valid), 64'd0);
        check("t3_count_after_redirect", 64'(count), 64'h40);
        check("t3_credit_held", 64'(imem_req), 64'd0);
        wait_drain("t3", 80);

        // 4: PC wrap 0xFE -> 0x01.
        do_reset(1'b1);
        lat = 1;
        push_exp(8'hFE, 4);
        instr_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 8'hFE;
        @(posedge clk1);
        #2;
        redirect = 1'b0;
        @(negedge clk1);
        check("t4_addr_fe", 64'(imem_addr), 64'hFE);
        wait_drain("t4", 60);

        // 5: reset mid-stream with two requests in flight.
        do_reset(1'b1);
        lat = 3;
        instr_ready = 1'b1;
        wait_count("t5_two_grants", 8'h02);
        reset = 1'b1;
        #1;
        check("t5_async_valid", 64'(instr_valid), 64'd0);
        check("t5_async_count", 64'(count), 64'd0);
        check("t5_async_req", 64'(imem_req), 64'd0);
        @(posedge clk1);
        #2;
        gnt_en = 1'b0;
        reset  = 1'b0;
        repeat (5) begin
            @(negedge clk1);
            check("t5_stale_ignored", 64'(instr_valid), 64'd0);
        end
        check("t5_count_held", 64'(count), 64'd0);
        push_exp(8'h00, 3);
        @(posedge clk1);
        #2;
        gnt_en = 1'b1;
        wait_drain("t5", 60);

        // 6: redirect coinciding with a response and a pop.
        do_reset(1'b1);
        lat = 1;
        push_exp(8'h00, 1);
        push_exp(8'h80, 3);
        instr_ready = 1'b1;
        n = 0;
        while (!(imem_rvalid && instr_valid) && n < 20) begin
            @(posedge clk1);
            #2;
            n++;
        end
        check("t6_coincidence", 64'(imem_rvalid && instr_valid), 64'd1);
        redirect    = 1'b1;
        redirect_pc = 8'h80;
        @(posedge clk1);
        #2;
        redirect = 1'b0;
        @(negedge clk1);
        check("t6_queue_empty", 64'(instr_valid), 64'd0);
        check("t6_addr", 64'(imem_addr), 64'h80);
        check("t6_req_resumes", 64'(imem_req), 64'd1);
        wait_drain("t6", 60);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the processor's control unit and datapath.
- Owns the program counter and issues word-addressed requests to instruction memory. Accepts in-order responses of variable latency into a small instruction queue, and presents instruction I plus its PC to decode with a valid/ready handshake.
- On a taken branch or jump (redirect), flushes the queue and discards stale in-flight responses.

Parameters:
- ADDR_W, 8, PC / instruction-memory word-address width; matches the 8-bit count bus.
- DATA_W, 32, instruction width.
- DEPTH, 2, queue entries; also the cap on queued plus outstanding requests (power of two, 2..8).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk1  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  request valid to instruction memory.
- imem_addr  out  ADDR_W  request word address; always equals count.
- imem_gnt  in  1  memory accepts the request this cycle (transfer = imem_req & imem_gnt).
- imem_rvalid  in  1  response valid; responses return in request order, at least 1 cycle after grant.
- imem_rdata  in  DATA_W  response instruction word.
- instr_valid  out  1  queue head valid to decode.
- instr  out  DATA_W  queue head instruction (drives I).
- instr_pc  out  ADDR_W  PC of queue head.
- instr_ready  in  1  decode consumes head this cycle (pop = instr_valid & instr_ready).
- redirect  in  1  taken branch or jump (PCsrc) this cycle.
- redirect_pc  in  ADDR_W  new fetch PC.
- count  out  ADDR_W  current fetch PC.

Behaviour:
- Reset, asynchronous and dominant at any time including mid-transfer:
  - count = RESET_PC; queue empty; outstanding = 0; drop = 0.
  - instr_valid = 0; instr = 0; instr_pc = 0; imem_req = 0 while reset is high.
- Credit rule:
  - imem_req = !reset & !redirect & (occupancy + outstanding < DEPTH).
  - imem_req is combinational; imem_addr = count.
- Grant:
  - count <= count + 1, modulo 2^ADDR_W (255 -> 0 wraps silently).
  - outstanding += 1.
  - The granted PC is pushed into a PC tag FIFO of depth DEPTH.
- Response (imem_rvalid):
  - outstanding -= 1 and the PC tag is popped.
  - If drop > 0: drop -= 1 and the data is discarded.
  - Otherwise {imem_rdata, tag} is enqueued.
  - imem_rvalid with outstanding = 0 is a protocol error; ignore it and leave state unchanged.
- Queue:
  - instr_valid = (occupancy != 0); instr and instr_pc show the head, held stable while instr_valid & !instr_ready.
  - Push and pop in the same cycle leave occupancy unchanged.
  - Push when full cannot occur because of the credit rule.
  - Minimum latency is 2 cycles: grant at cycle N, rvalid at N+1, instr_valid at N+2.
- Redirect (highest priority after reset):
  - count <= redirect_pc; queue cleared, so instr_valid = 0 next cycle.
  - drop <= outstanding_next, i.e. all requests still in flight after this edge, including one granted this cycle if the memory does so (imem_req is forced 0, so none should be) and excluding a response arriving and consumed this cycle.
  - A pop in the same cycle is harmless; the queue is cleared regardless.
  - A response arriving in the redirect cycle is discarded.
  - Fetch resumes at redirect_pc the following cycle.
  - Back-to-back redirects: the last one wins; drop accumulates correctly.
- Counter widths: outstanding, drop and occupancy are each clog2(DEPTH)+1 bits and must never underflow.
- instr and instr_pc hold their last value when the queue empties; they are not zeroed.

Test Plan:
- Reset then free-running memory with 1-cycle latency and instr_ready = 1 -> imem_addr 0,1,2,...; instr_pc 0,1,2,... starting cycle 2; one instruction per cycle; count reaches 3 after three grants.
- instr_ready = 0 for 6 cycles -> exactly 2 instructions (PC 0,1) queued; imem_req drops to 0; instr holds the PC 0 word stably; releasing ready drains in order.
- Memory latency 3 with 2 outstanding, redirect to 0x40 at cycle 4 -> both late responses dropped; next instr_valid shows instr_pc = 0x40 with the data returned for address 0x40.
- count = 0xFE, free-running -> addresses 0xFE, 0xFF, 0x00, 0x01; instr_pc wraps identically.
- Assert reset mid-stream with 2 outstanding, then release -> instr_valid = 0 and count = RESET_PC immediately; stale responses after release are ignored as protocol errors; fetch restarts at 0.
- Redirect coinciding with imem_rvalid and a pop -> response discarded, queue empty next cycle, drop equals the remaining outstanding count, and no instruction from the old path ever reaches instr_valid.
